// File: rtl/stage2_decode.sv
// stage2_decode
//   Receive-side inverse of the stage-2 check-bit encoder. Each accepted 17-bit
//   word {payload[15:0], chk} returns its payload one cycle later. The check bit
//   is verified against a key-selected reduction of the PREVIOUS payload, because
//   the encoder appends f(previous data). Mismatches feed a saturating total-error
//   counter. A run of ERR_LIMIT consecutive mismatches latches FAULT, which holds
//   until resync or reset.
//
// Parameters
//   ERR_LIMIT   consecutive mismatches that force FAULT (0 = never fault)
//   CNT_W       width of the saturating total-error counter
//
// Ports
//   clk2        in   1      clock, rising edge
//   rst         in   1      synchronous active-low reset
//   key_bits    in   5      [1:0] selects the check function, [4:2] unused
//   stg2_in     in   17     [16:1] payload, [0] check bit
//   stg2_valid  in   1      stg2_in valid this cycle
//   resync      in   1      drop check history; the next word is taken unchecked
//   dec_out     out  16     decoded payload
//   done        out  1      one-cycle pulse: dec_out/chk_err updated
//   chk_err     out  1      check result for the word flagged by done
//   err_cnt     out  CNT_W  total mismatches since reset, saturating
//   fault       out  1      high while in FAULT
module stage2_decode #(
   parameter int ERR_LIMIT = 3,
   parameter int CNT_W     = 8
) (
   input  logic             clk2,
   input  logic             rst,
   input  logic [4:0]       key_bits,
   input  logic [16:0]      stg2_in,
   input  logic             stg2_valid,
   input  logic             resync,
   output logic [15:0]      dec_out,
   output logic             done,
   output logic             chk_err,
   output logic [CNT_W-1:0] err_cnt,
   output logic             fault
);

   typedef enum logic [1:0] {ST_RUN, ST_SYNC, ST_FAULT} state_t;

   // The consecutive-error count saturates so it cannot wrap when faulting is
   // disabled; ERR_LIMIT is expected to stay below its ceiling.
   localparam int            CONSEC_W = 8;
   localparam logic [CONSEC_W-1:0] LIMIT = CONSEC_W'(ERR_LIMIT);

   state_t              state, state_n;
   logic [15:0]         prev_data, prev_n;
   logic [CONSEC_W-1:0] consec, consec_n, consec_inc;
   logic [15:0]         dec_n;
   logic                done_n, chk_n, fault_n, mism;
   logic [CNT_W-1:0]    cnt_n;
   logic [15:0]         payload;
   logic                unused_key;

   // Check function shared with the encoder.
   function automatic logic chk_fn(input logic [1:0] k, input logic [15:0] d);
      case (k)
         2'b00:   chk_fn = ~^d;
         2'b10:   chk_fn = &d;
         default: chk_fn = |d;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
      sat_cnt = (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [CONSEC_W-1:0] sat_consec(input logic [CONSEC_W-1:0] v);
      sat_consec = (&v) ? v : v + 1'b1;
   endfunction

   assign unused_key = ^key_bits[4:2];
   assign payload    = stg2_in[16:1];
   assign mism       = stg2_in[0] != chk_fn(key_bits[1:0], prev_data);
   assign consec_inc = sat_consec(consec);

   // Next-state / next-output logic
   always_comb begin
      state_n  = state;
      prev_n   = prev_data;
      consec_n = consec;
      dec_n    = dec_out;
      done_n   = 1'b0;
      chk_n    = chk_err;
      cnt_n    = err_cnt;
      fault_n  = fault;
      if (resync) begin
         // Resync wins over any word presented in the same cycle.
         state_n  = ST_SYNC;
         fault_n  = 1'b0;
         consec_n = '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (stg2_valid) begin
                  done_n = 1'b1;
                  dec_n  = payload;
                  chk_n  = mism;
                  prev_n = payload;
                  if (mism) begin
                     consec_n = consec_inc;
                     cnt_n    = sat_cnt(err_cnt);
                     if (ERR_LIMIT != 0 && consec_inc >= LIMIT) begin
                        state_n = ST_FAULT;
                        fault_n = 1'b1;
                     end
                  end else begin
                     consec_n = '0;
                  end
               end
            end
            ST_SYNC: begin
               // First word after resync has no trusted history: take it unchecked.
               if (stg2_valid) begin
                  done_n   = 1'b1;
                  dec_n    = payload;
                  chk_n    = 1'b0;
                  prev_n   = payload;
                  consec_n = '0;
                  state_n  = ST_RUN;
               end
            end
            default: ; // FAULT: input ignored, everything holds
         endcase
      end
   end

   // State / output registers
   always_ff @(posedge clk2) begin
      if (!rst) begin
         state     <= ST_RUN;
         prev_data <= '0;
         consec    <= '0;
         dec_out   <= '0;
         done      <= 1'b0;
         chk_err   <= 1'b0;
         err_cnt   <= '0;
         fault     <= 1'b0;
      end else begin
         state     <= state_n;
         prev_data <= prev_n;
         consec    <= consec_n;
         dec_out   <= dec_n;
         done      <= done_n;
         chk_err   <= chk_n;
         err_cnt   <= cnt_n;
         fault     <= fault_n;
      end
   end

endmodule

// File: tb/tb_stage2_decode.sv
// Testbench for stage2_decode: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model. Two instances
// share the stimulus: dut_a (ERR_LIMIT=3) and dut_b (ERR_LIMIT=0).
module tb_stage2_decode;

   logic clk2 = 1'b0;
   always #5 clk2 = ~clk2;

   logic        rst;
   logic [4:0]  key_bits;
   logic [16:0] stg2_in;
   logic        stg2_valid;
   logic        resync;

   logic [15:0] a_dec, b_dec;
   logic        a_done, b_done, a_chk, b_chk, a_fault, b_fault;
   logic [7:0]  a_cnt, b_cnt;

   stage2_decode #(.ERR_LIMIT(3), .CNT_W(8)) dut_a (
      .clk2(clk2), .rst(rst), .key_bits(key_bits), .stg2_in(stg2_in),
      .stg2_valid(stg2_valid), .resync(resync), .dec_out(a_dec), .done(a_done),
      .chk_err(a_chk), .err_cnt(a_cnt), .fault(a_fault));

   stage2_decode #(.ERR_LIMIT(0), .CNT_W(8)) dut_b (
      .clk2(clk2), .rst(rst), .key_bits(key_bits), .stg2_in(stg2_in),
      .stg2_valid(stg2_valid), .resync(resync), .dec_out(b_dec), .done(b_done),
      .chk_err(b_chk), .err_cnt(b_cnt), .fault(b_fault));

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic        rst_n;
      logic [1:0]  key;
      logic [15:0] d;
      logic        c;
      logic        v;
      logic        rs;
      logic        e_done;
      logic [15:0] e_dec;
      logic        e_chk;
      logic [7:0]  e_cnt;
      logic        e_fault;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rst_n, logic [1:0] key, logic [15:0] d, logic c,
                               logic v, logic rs, logic e_done, logic [15:0] e_dec,
                               logic e_chk, logic [7:0] e_cnt, logic e_fault);
      vec_t t;
      t.rst_n = rst_n; t.key = key; t.d = d; t.c = c; t.v = v; t.rs = rs;
      t.e_done = e_done; t.e_dec = e_dec; t.e_chk = e_chk; t.e_cnt = e_cnt;
      t.e_fault = e_fault;
      return t;
   endfunction

   task automatic cmp(input string nm, input logic adone, input logic [15:0] adec,
                      input logic achk, input logic [7:0] acnt, input logic afl,
                      input logic edone, input logic [15:0] edec, input logic echk,
                      input logic [7:0] ecnt, input logic efl);
      n_vec++;
      if ({adone, adec, achk, acnt, afl} !== {edone, edec, echk, ecnt, efl}) begin
         n_bad++;
         $display("FAIL %s: got done=%b dec=%h chk=%b cnt=%0d fault=%b, expected done=%b dec=%h chk=%b cnt=%0d fault=%b",
                  nm, adone, adec, achk, acnt, afl, edone, edec, echk, ecnt, efl);
      end
   endtask

   task automatic drive(input logic rst_n, input logic [1:0] key, input logic [15:0] d,
                        input logic c, input logic v, input logic rs);
      rst        = rst_n;
      key_bits   = {3'($urandom_range(7)), key};
      stg2_in    = {d, c};
      stg2_valid = v;
      resync     = rs;
   endtask

   task automatic tick();
      @(posedge clk2);
      #1;
   endtask

   // Behavioural model: mode 0 = checking, 1 = next word unchecked, 2 = faulted.
   logic [15:0] m_prev[2], m_dec[2];
   int          m_consec[2], m_mode[2], m_cnt[2];
   logic        m_done[2], m_chk[2], m_fault[2];

   function automatic logic fref(logic [1:0] k, logic [15:0] d);
      case (k)
         2'd0:    return ($countones(d) % 2) == 0;
         2'd2:    return d == 16'hFFFF;
         default: return d != 16'h0000;
      endcase
   endfunction

   task automatic model_step(input int i, input int lim);
      logic bad;
      m_done[i] = 1'b0;
      if (!rst) begin
         m_prev[i] = '0; m_dec[i] = '0; m_consec[i] = 0; m_mode[i] = 0;
         m_cnt[i] = 0; m_chk[i] = 1'b0; m_fault[i] = 1'b0;
      end else if (resync) begin
         m_mode[i] = 1; m_fault[i] = 1'b0; m_consec[i] = 0;
      end else if (stg2_valid && m_mode[i] != 2) begin
         bad       = (m_mode[i] == 0) && (stg2_in[0] != fref(key_bits[1:0], m_prev[i]));
         m_done[i] = 1'b1;
         m_dec[i]  = stg2_in[16:1];
         m_chk[i]  = bad;
         m_prev[i] = stg2_in[16:1];
         m_mode[i] = 0;
         if (bad) begin
            m_consec[i]++;
            if (m_cnt[i] < 255) m_cnt[i]++;
            if (lim != 0 && m_consec[i] >= lim) begin
               m_mode[i]  = 2;
               m_fault[i] = 1'b1;
            end
         end else begin
            m_consec[i] = 0;
         end
      end
   endtask

   initial begin
      drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0);

      // Reset, key 00, history ~^0 = 1
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
      tbl.push_back(mk(1, 0, 16'h1234, 1, 1, 0, 1, 16'h1234, 0, 0, 0));
      tbl.push_back(mk(1, 0, 16'hABCD, 0, 1, 0, 1, 16'hABCD, 0, 0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 16'hABCD, 0, 0, 0));
      // Key 01: mismatch then match
      tbl.push_back(mk(0, 1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
      tbl.push_back(mk(1, 1, 16'h0001, 1, 1, 0, 1, 16'h0001, 1, 1, 0));
      tbl.push_back(mk(1, 1, 16'h0002, 1, 1, 0, 1, 16'h0002, 0, 1, 0));
      // Key 10: three failures -> FAULT, 4th word ignored
      tbl.push_back(mk(0, 2, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
      tbl.push_back(mk(1, 2, 16'h0000, 1, 1, 0, 1, 16'h0000, 1, 1, 0));
      tbl.push_back(mk(1, 2, 16'h0000, 1, 1, 0, 1, 16'h0000, 1, 2, 0));
      tbl.push_back(mk(1, 2, 16'h0000, 1, 1, 0, 1, 16'h0000, 1, 3, 1));
      tbl.push_back(mk(1, 2, 16'h5555, 1, 1, 0, 0, 16'h0000, 1, 3, 1));
      // Resync out of FAULT, unchecked word, then &0x00FF = 0
      tbl.push_back(mk(1, 2, 16'h0000, 0, 0, 1, 0, 16'h0000, 1, 3, 0));
      tbl.push_back(mk(1, 2, 16'h00FF, 1, 1, 0, 1, 16'h00FF, 0, 3, 0));
      tbl.push_back(mk(1, 2, 16'h0000, 0, 1, 0, 1, 16'h0000, 0, 3, 0));
      // Resync with a valid word: dropped; next word unchecked, then checked again
      tbl.push_back(mk(1, 2, 16'hFFFF, 1, 1, 1, 0, 16'h0000, 0, 3, 0));
      tbl.push_back(mk(1, 2, 16'h2222, 1, 1, 0, 1, 16'h2222, 0, 3, 0));
      tbl.push_back(mk(1, 2, 16'h0001, 0, 1, 0, 1, 16'h0001, 0, 3, 0));
      tbl.push_back(mk(1, 2, 16'h0001, 1, 1, 0, 1, 16'h0001, 1, 4, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst_n, tbl[i].key, tbl[i].d, tbl[i].c, tbl[i].v, tbl[i].rs);
         tick();
         cmp($sformatf("vec%0d", i), a_done, a_dec, a_chk, a_cnt, a_fault,
             tbl[i].e_done, tbl[i].e_dec, tbl[i].e_chk, tbl[i].e_cnt, tbl[i].e_fault);
      end

      // 300 bad words: counter saturates on dut_b, dut_a faults at 3
      drive(1'b0, 2'd1, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      cmp("sat_reset_b", b_done, b_dec, b_chk, b_cnt, b_fault, 0, 16'h0, 0, 8'd0, 0);
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 2'd1, 16'h0000, 1'b1, 1'b1, 1'b0);
         tick();
      end
      cmp("sat_b", b_done, b_dec, b_chk, b_cnt, b_fault, 1, 16'h0, 1, 8'd255, 0);
      cmp("sat_a", a_done, a_dec, a_chk, a_cnt, a_fault, 0, 16'h0, 1, 8'd3, 1);
      // Reset mid-stream with a valid word present
      drive(1'b0, 2'd1, 16'hBEEF, 1'b1, 1'b1, 1'b0);
      tick();
      cmp("midrst_a", a_done, a_dec, a_chk, a_cnt, a_fault, 0, 16'h0, 0, 8'd0, 0);
      cmp("midrst_b", b_done, b_dec, b_chk, b_cnt, b_fault, 0, 16'h0, 0, 8'd0, 0);

      // Randomized run against the model
      drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0);
      model_step(0, 3);
      model_step(1, 0);
      tick();
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] d;
         case ($urandom_range(3))
            0:       d = 16'h0000;
            1:       d = 16'hFFFF;
            default: d = 16'($urandom);
         endcase
         drive($urandom_range(60) != 0, 2'($urandom_range(3)), d, 1'($urandom_range(1)),
               $urandom_range(9) < 7, $urandom_range(24) == 0);
         model_step(0, 3);
         model_step(1, 0);
         tick();
         cmp($sformatf("rnd_a%0d", i), a_done, a_dec, a_chk, a_cnt, a_fault,
             m_done[0], m_dec[0], m_chk[0], 8'(m_cnt[0]), m_fault[0]);
         cmp($sformatf("rnd_b%0d", i), b_done, b_dec, b_chk, b_cnt, b_fault,
             m_done[1], m_dec[1], m_chk[1], 8'(m_cnt[1]), m_fault[1]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
